// File: rtl/digit_scan_driver.sv
// Time-multiplexed driver for a 6-digit common-anode 7-segment display, with frame-aligned data commit.
// Optional build macro LEADING_ZERO_BLANK_EN: suppress leading zeros in d1..d5.
module digit_scan_driver #(
    parameter int DWELL = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    input  logic [3:0] d5,
    input  logic [3:0] d6,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       pending,
    output logic       frame_done
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [3:0]    r_shadow [6];
    logic [3:0]    r_buf    [6];
    logic          r_pending;
    logic          r_frame_done;
    logic [5:0]    r_an;
    logic [6:0]    r_seg;

    logic          w_wrap;
    logic          w_boundary;
    logic [3:0]    w_code;
    logic          w_blank;
    logic [5:0]    w_an_next;
    logic [6:0]    w_seg_next;
`ifdef LEADING_ZERO_BLANK_EN
    logic          w_lead;
`endif

    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'h0:    decode = 7'b1000000;
            4'h1:    decode = 7'b1111001;
            4'h2:    decode = 7'b0100100;
            4'h3:    decode = 7'b0110000;
            4'h4:    decode = 7'b0011001;
            4'h5:    decode = 7'b0010010;
            4'h6:    decode = 7'b0000010;
            4'h7:    decode = 7'b1111000;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0010000;
            4'hA:    decode = 7'b0111111;
            4'hB:    decode = 7'b0000110;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign w_wrap     = (r_cnt == CNT_MAX);
    assign w_boundary = w_wrap && (r_idx == 3'd5);

    always_comb begin
        w_code    = 4'hF;
        w_blank   = 1'b0;
        w_an_next = 6'b111111;
        case (r_idx)
            3'd0: begin w_code = r_shadow[0]; w_an_next = 6'b011111; end
            3'd1: begin w_code = r_shadow[1]; w_an_next = 6'b101111; end
            3'd2: begin w_code = r_shadow[2]; w_an_next = 6'b110111; end
            3'd3: begin w_code = r_shadow[3]; w_an_next = 6'b111011; end
            3'd4: begin w_code = r_shadow[4]; w_an_next = 6'b111101; end
            3'd5: begin w_code = r_shadow[5]; w_an_next = 6'b111110; end
            default: begin w_code = 4'hF; w_an_next = 6'b111111; end
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        // A zero is leading while everything left of it is zero, blank or '-'; d6 is excluded.
        w_lead = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (r_idx == 3'(k))
                w_blank = w_lead && (r_shadow[k] == 4'h0);
            w_lead = w_lead && ((r_shadow[k] == 4'h0) || (r_shadow[k] >= 4'hC) ||
                                (r_shadow[k] == 4'hA));
        end
`endif
        w_seg_next = w_blank ? 7'b1111111 : decode(w_code);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= 3'd0;
            r_shadow     <= '{default: 4'hF};
            r_buf        <= '{default: 4'hF};
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_an         <= 6'b111111;
            r_seg        <= 7'b1111111;
        end else begin
            r_cnt        <= w_wrap ? '0 : r_cnt + CW'(1);
            if (w_wrap)
                r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            r_frame_done <= w_boundary;
            // Commit reads the old buffer, so a load on the boundary lands in the next frame.
            if (w_boundary && r_pending)
                r_shadow <= r_buf;
            if (load) begin
                r_buf     <= '{d1, d2, d3, d4, d5, d6};
                r_pending <= 1'b1;
            end else if (w_boundary) begin
                r_pending <= 1'b0;
            end
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign pending    = r_pending;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Bench for digit_scan_driver (DWELL=4): directed loads, expected digit slots queued per frame.
module tb_digit_scan_driver;
  localparam int DWELL = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SM = 7'b0111111;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SB = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] d1 = 4'hF, d2 = 4'hF, d3 = 4'hF, d4 = 4'hF, d5 = 4'hF, d6 = 4'hF;
  logic [5:0] an;
  logic [6:0] seg;
  logic       pending;
  logic       frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [12:0] exp_q[$];

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  digit_scan_driver #(.DWELL(DWELL)) dut (
    .clk(clk), .reset(reset), .load(load),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
    .an(an), .seg(seg), .pending(pending), .frame_done(frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_digits(input logic [3:0] a, b, c, d, e, f);
    d1 = a; d2 = b; d3 = c; d4 = d; d5 = e; d6 = f;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic push_frame(input logic [6:0] s1, s2, s3, s4, s5, s6);
    exp_q.push_back({6'b011111, s1});
    exp_q.push_back({6'b101111, s2});
    exp_q.push_back({6'b110111, s3});
    exp_q.push_back({6'b111011, s4});
    exp_q.push_back({6'b111101, s5});
    exp_q.push_back({6'b111110, s6});
  endtask

  task automatic wait_fd(output int at);
    int k;
    k = 0;
    while (frame_done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("frame_done_seen", frame_done, 1);
    at = cyc;
  endtask

  // load mid-frame, wait for the commit, queue the frame that follows
  task automatic frame_cycle(input logic [3:0] a, b, c, d, e, f,
                             input logic [6:0] s1, s2, s3, s4, s5, s6);
    int t;
    tick(5);
    load_digits(a, b, c, d, e, f);
    check("pending_after_load", pending, 1);
    wait_fd(t);
    check("pending_cleared", pending, 0);
    push_frame(s1, s2, s3, s4, s5, s6);
    tick(1);
    check("frame_done_one_cycle", frame_done, 0);
  endtask

  // scoreboard monitor: each new digit slot pops one expectation
  initial begin
    logic [5:0]  prev_an;
    logic [12:0] e;
    int run;
    prev_an = 6'h3F;
    run = 0;
    forever begin
      @(negedge clk);
      if (an !== prev_an) begin
        if (an !== 6'h3F && prev_an !== 6'h3F)
          check("dwell", run, DWELL);
        if (an !== 6'h3F && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("slot", {an, seg}, e);
        end
        prev_an = an;
        run = 1;
      end else begin
        run++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, t2, t3, t4;
    reset = 1'b1;
    tick(3);
    check("reset_an", an, 6'h3F);
    check("reset_seg", seg, 7'h7F);
    check("reset_pending", pending, 0);
    check("reset_frame_done", frame_done, 0);
    reset = 1'b0;
    tick(2);
    load_digits(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6);
    check("pending_pre_reset", pending, 1);
    tick(3);

    // asynchronous reset mid-scan, observed before any clock edge
    reset = 1'b1;
    #1;
    check("async_an", an, 6'h3F);
    check("async_seg", seg, 7'h7F);
    check("async_pending", pending, 0);
    check("async_frame_done", frame_done, 0);
    tick(2);
    reset = 1'b0;

    // first frame after reset is blank even though a load is pending
    push_frame(SB, SB, SB, SB, SB, SB);
    load_digits(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6);
    check("pending_after_load", pending, 1);
    wait_fd(t0);
    check("pending_cleared", pending, 0);
    push_frame(S1, S2, S3, S4, S5, S6);
    tick(1);
    check("frame_done_one_cycle", frame_done, 0);

    // mid-frame load of 9s: current frame keeps 1..6
    tick(7);
    load_digits(4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9);
    check("pending_mid_frame", pending, 1);
    wait_fd(t1);
    check("frame_period", t1 - t0, 6 * DWELL);
    check("pending_cleared", pending, 0);
    push_frame(S9, S9, S9, S9, S9, S9);
    tick(1);

    // two loads before a boundary: latest wins
    tick(3);
    load_digits(4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7);
    tick(4);
    load_digits(4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8);
    wait_fd(t2);
    check("frame_period", t2 - t1, 6 * DWELL);
    check("pending_cleared", pending, 0);
    push_frame(S8, S8, S8, S8, S8, S8);

    // 3s pending, then a load exactly on the boundary cycle
    tick(4);
    load_digits(4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3);
    tick(18);
    load_digits(4'hA, 4'hB, 4'hF, 4'h0, 4'h0, 4'h0);
    t3 = cyc;
    check("boundary_load_frame_done", frame_done, 1);
    check("boundary_load_pending", pending, 1);
    check("frame_period", t3 - t2, 6 * DWELL);
    push_frame(S3, S3, S3, S3, S3, S3);
    tick(1);
    check("frame_done_one_cycle", frame_done, 0);
    wait_fd(t4);
    check("frame_period", t4 - t3, 6 * DWELL);
    check("pending_cleared", pending, 0);
    push_frame(SM, SE, SB, S0, S0, S0);
    tick(1);

`ifdef LEADING_ZERO_BLANK_EN
    frame_cycle(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7, SB, SB, SB, SB, SB, S7);
    frame_cycle(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, SB, SB, SB, SB, SB, S0);
    frame_cycle(4'hA, 4'h0, 4'h0, 4'h1, 4'h0, 4'h3, SM, SB, SB, S1, S0, S3);
`else
    frame_cycle(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7, S0, S0, S0, S0, S0, S7);
    frame_cycle(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, S0, S0, S0, S0, S0, S0);
    frame_cycle(4'hA, 4'h0, 4'h0, 4'h1, 4'h0, 4'h3, SM, S0, S0, S1, S0, S3);
`endif

    tick(26);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
